// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, col/row counters,
// sync/data-enable flags and line/frame strobes, all registered on the same pixel.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 2,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_tick,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW1     = CNT_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    // Region bounds carry one extra bit so a sync pulse ending exactly at
    // 2^CNT_W does not wrap to zero.
    localparam logic [CW1-1:0] H_DE_END   = CW1'(H_DISPLAY);
    localparam logic [CW1-1:0] H_SYNC_BEG = CW1'(H_DISPLAY + H_FRONT);
    localparam logic [CW1-1:0] H_SYNC_END = CW1'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW1-1:0] V_DE_END   = CW1'(V_DISPLAY);
    localparam logic [CW1-1:0] V_SYNC_BEG = CW1'(V_DISPLAY + V_FRONT);
    localparam logic [CW1-1:0] V_SYNC_END = CW1'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic [CNT_W-1:0] col_n;
    logic [CNT_W-1:0] row_n;
    logic [CW1-1:0]   col_x;
    logic [CW1-1:0]   row_x;
    logic             h_sync_act;
    logic             v_sync_act;

    assign tick = en & (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        end
    end

    // Next raster position if this clk carries a pixel advance.
    always_comb begin
        col_n = (col_q == H_LAST) ? '0 : col_q + CNT_ONE;
        row_n = row_q;
        if (col_q == H_LAST) begin
            row_n = (row_q == V_LAST) ? '0 : row_q + CNT_ONE;
        end
        col_x      = {1'b0, col_n};
        row_x      = {1'b0, row_n};
        h_sync_act = (col_x >= H_SYNC_BEG) && (col_x < H_SYNC_END);
        v_sync_act = (row_x >= V_SYNC_BEG) && (row_x < V_SYNC_END);
    end

    // Flags are derived from the next position so they land together with it.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            col_d         = col_n;
            row_d         = row_n;
            de_d          = (col_x < H_DE_END) && (row_x < V_DE_END);
            hsync_d       = h_sync_act ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = v_sync_act ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (col_n == '0);
            frame_start_d = (col_n == '0) && (row_n == '0);
        end
    end

    // Reset parks the raster on its last position so the first tick lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            col_q         <= H_LAST;
            row_q         <= V_LAST;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = tick;
    assign col         = col_q;
    assign row         = row_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every cycle against a
// raster model, plus directed checks with hand-computed positions and flag levels.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults; 1: small raster, CLK_DIV=3; 2: tiny raster, CLK_DIV=1, positive syncs.
    int hd [3] = '{640, 8, 4};
    int hf [3] = '{16, 2, 1};
    int hs [3] = '{96, 3, 1};
    int hb [3] = '{48, 2, 1};
    int vd [3] = '{480, 6, 3};
    int vf [3] = '{10, 2, 1};
    int vs [3] = '{2, 2, 1};
    int vb [3] = '{33, 2, 1};
    int dv [3] = '{2, 3, 1};
    bit hp [3] = '{1'b0, 1'b0, 1'b1};
    bit vp [3] = '{1'b0, 1'b0, 1'b1};

    logic       rst_v [3];
    logic       en_v [3];
    logic       pix_tick_v [3];
    logic [9:0] col_v [3];
    logic [9:0] row_v [3];
    logic       hsync_v [3];
    logic       vsync_v [3];
    logic       de_v [3];
    logic       ls_v [3];
    logic       fs_v [3];

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .pix_tick(pix_tick_v[0]),
        .col(col_v[0]), .row(row_v[0]), .hsync(hsync_v[0]), .vsync(vsync_v[0]),
        .de(de_v[0]), .line_start(ls_v[0]), .frame_start(fs_v[0])
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .CLK_DIV(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(10)
    ) dut_b (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .pix_tick(pix_tick_v[1]),
        .col(col_v[1]), .row(row_v[1]), .hsync(hsync_v[1]), .vsync(vsync_v[1]),
        .de(de_v[1]), .line_start(ls_v[1]), .frame_start(fs_v[1])
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(10)
    ) dut_c (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .pix_tick(pix_tick_v[2]),
        .col(col_v[2]), .row(row_v[2]), .hsync(hsync_v[2]), .vsync(vsync_v[2]),
        .de(de_v[2]), .line_start(ls_v[2]), .frame_start(fs_v[2])
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: linear pixel index within the frame, enabled clocks since reset,
    // and the strobes expected after the most recent edge.
    int lin [3];
    int ecnt [3];
    bit ls_m [3];
    bit fs_m [3];

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            if (n_miss <= 40)
                $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", nm, inst, $time, got, exp);
        end
    endtask

    function automatic int h_tot(input int i);
        return hd[i] + hf[i] + hs[i] + hb[i];
    endfunction

    function automatic int v_tot(input int i);
        return vd[i] + vf[i] + vs[i] + vb[i];
    endfunction

    task automatic model_reset(input int i);
        lin[i]  = h_tot(i) * v_tot(i) - 1;
        ecnt[i] = 0;
        ls_m[i] = 1'b0;
        fs_m[i] = 1'b0;
    endtask

    // Per-cycle compare, then advance the model by the edge that follows.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  ht, c, r;
            bit  e_tick, e_de, e_hs, e_vs;
            ht     = h_tot(i);
            c      = lin[i] % ht;
            r      = lin[i] / ht;
            e_tick = en_v[i] && ((ecnt[i] % dv[i]) == dv[i] - 1);
            e_de   = (c < hd[i]) && (r < vd[i]);
            e_hs   = (c >= hd[i] + hf[i] && c < hd[i] + hf[i] + hs[i]) ? hp[i] : !hp[i];
            e_vs   = (r >= vd[i] + vf[i] && r < vd[i] + vf[i] + vs[i]) ? vp[i] : !vp[i];
            chk("pix_tick", i, 32'(pix_tick_v[i]), 32'(e_tick));
            chk("col", i, 32'(col_v[i]), c);
            chk("row", i, 32'(row_v[i]), r);
            chk("de", i, 32'(de_v[i]), 32'(e_de));
            chk("hsync", i, 32'(hsync_v[i]), 32'(e_hs));
            chk("vsync", i, 32'(vsync_v[i]), 32'(e_vs));
            chk("line_start", i, 32'(ls_v[i]), 32'(ls_m[i]));
            chk("frame_start", i, 32'(fs_v[i]), 32'(fs_m[i]));
            if (rst_v[i]) begin
                model_reset(i);
            end else begin
                ls_m[i] = 1'b0;
                fs_m[i] = 1'b0;
                if (e_tick) begin
                    lin[i]  = (lin[i] + 1) % (ht * v_tot(i));
                    ls_m[i] = (lin[i] % ht) == 0;
                    fs_m[i] = (lin[i] == 0);
                end
                if (en_v[i]) ecnt[i]++;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int i, input int c, input int r, input int limit);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            step();
            if (col_v[i] == 10'(c) && row_v[i] == 10'(r)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_pos inst=%0d got=(%0d,%0d) expected=(%0d,%0d) within %0d clk",
                     i, col_v[i], row_v[i], c, r, limit);
        end
    endtask

    task automatic edges_until_col(input int i, input int c, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (col_v[i] != 10'(c) && n < limit);
    endtask

    task automatic frame_len(input int i, input int exp, input string nm);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (fs_v[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            do begin
                step();
                n++;
            end while (fs_v[i] !== 1'b1 && n < 3000);
        end
        chk(nm, i, n, exp);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            rst_v[i] = 1'b1;
            en_v[i]  = 1'b0;
        end
        step();
        step();

        // Reset state of the default raster.
        chk("a_rst_col", 0, 32'(col_v[0]), 799);
        chk("a_rst_row", 0, 32'(row_v[0]), 524);
        chk("a_rst_de", 0, 32'(de_v[0]), 0);
        chk("a_rst_hsync", 0, 32'(hsync_v[0]), 1);
        chk("a_rst_vsync", 0, 32'(vsync_v[0]), 1);
        chk("a_rst_fs", 0, 32'(fs_v[0]), 0);

        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b1;
        end
        step();
        chk("a_clk1_col", 0, 32'(col_v[0]), 799);
        chk("a_clk1_tick", 0, 32'(pix_tick_v[0]), 1);
        step();
        chk("a_first_col", 0, 32'(col_v[0]), 0);
        chk("a_first_row", 0, 32'(row_v[0]), 0);
        chk("a_first_de", 0, 32'(de_v[0]), 1);
        chk("a_first_fs", 0, 32'(fs_v[0]), 1);
        chk("a_first_ls", 0, 32'(ls_v[0]), 1);
        step();
        chk("a_fs_width", 0, 32'(fs_v[0]), 0);
        chk("a_ls_width", 0, 32'(ls_v[0]), 0);

        // Full line on the default raster.
        wait_pos(0, 639, 0, 2000);
        chk("a_de_639", 0, 32'(de_v[0]), 1);
        wait_pos(0, 640, 0, 10);
        chk("a_de_640", 0, 32'(de_v[0]), 0);
        edges_until_col(0, 641, 10, n);
        chk("a_tick_period", 0, n, 2);
        wait_pos(0, 655, 0, 100);
        chk("a_hs_655", 0, 32'(hsync_v[0]), 1);
        wait_pos(0, 656, 0, 10);
        chk("a_hs_656", 0, 32'(hsync_v[0]), 0);
        wait_pos(0, 751, 0, 400);
        chk("a_hs_751", 0, 32'(hsync_v[0]), 0);
        wait_pos(0, 752, 0, 10);
        chk("a_hs_752", 0, 32'(hsync_v[0]), 1);
        wait_pos(0, 799, 0, 200);
        edges_until_col(0, 0, 10, n);
        chk("a_wrap_edges", 0, n, 2);
        chk("a_wrap_row", 0, 32'(row_v[0]), 1);
        chk("a_wrap_ls", 0, 32'(ls_v[0]), 1);
        chk("a_wrap_fs", 0, 32'(fs_v[0]), 0);

        // Pause for 7 clk at col 100; the pixel resumes after the remaining div count.
        wait_pos(0, 100, 1, 400);
        en_v[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("a_pause_col", 0, 32'(col_v[0]), 100);
            chk("a_pause_tick", 0, 32'(pix_tick_v[0]), 0);
            chk("a_pause_de", 0, 32'(de_v[0]), 1);
        end
        en_v[0] = 1'b1;
        edges_until_col(0, 101, 10, n);
        chk("a_resume_edges", 0, n, 2);

        // Mid-frame reset restarts as from power-up.
        wait_pos(0, 400, 20, 40000);
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        chk("a_mrst_col", 0, 32'(col_v[0]), 799);
        chk("a_mrst_row", 0, 32'(row_v[0]), 524);
        chk("a_mrst_de", 0, 32'(de_v[0]), 0);
        chk("a_mrst_hsync", 0, 32'(hsync_v[0]), 1);
        step();
        chk("a_mrst_clk1_col", 0, 32'(col_v[0]), 799);
        step();
        chk("a_mrst_first_col", 0, 32'(col_v[0]), 0);
        chk("a_mrst_first_row", 0, 32'(row_v[0]), 0);
        chk("a_mrst_first_fs", 0, 32'(fs_v[0]), 1);

        // Small raster: 15 x 12 pixels, 3 clk each; vsync active for rows 8-9.
        wait_pos(1, 7, 5, 2000);
        chk("b_de_7_5", 1, 32'(de_v[1]), 1);
        wait_pos(1, 0, 6, 100);
        chk("b_de_0_6", 1, 32'(de_v[1]), 0);
        wait_pos(1, 14, 7, 200);
        chk("b_vs_row7", 1, 32'(vsync_v[1]), 1);
        wait_pos(1, 0, 8, 10);
        chk("b_vs_row8", 1, 32'(vsync_v[1]), 0);
        wait_pos(1, 14, 9, 200);
        chk("b_vs_row9", 1, 32'(vsync_v[1]), 0);
        wait_pos(1, 0, 10, 10);
        chk("b_vs_row10", 1, 32'(vsync_v[1]), 1);
        frame_len(1, 540, "b_frame_len");

        // Tiny raster, one pixel per clk, active-high syncs.
        wait_pos(2, 4, 0, 200);
        chk("c_hs_col4", 2, 32'(hsync_v[2]), 0);
        wait_pos(2, 5, 0, 5);
        chk("c_hs_col5", 2, 32'(hsync_v[2]), 1);
        wait_pos(2, 6, 0, 5);
        chk("c_hs_col6", 2, 32'(hsync_v[2]), 0);
        chk("c_tick_const", 2, 32'(pix_tick_v[2]), 1);
        wait_pos(2, 6, 3, 100);
        chk("c_vs_row3", 2, 32'(vsync_v[2]), 0);
        wait_pos(2, 0, 4, 5);
        chk("c_vs_row4", 2, 32'(vsync_v[2]), 1);
        wait_pos(2, 0, 5, 20);
        chk("c_vs_row5", 2, 32'(vsync_v[2]), 0);
        frame_len(2, 42, "c_frame_len");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
